// File: rtl/mul8_share_arb.sv
// rtl/mul8_share_arb.sv - round-robin arbiter sharing one 8x8 multiplier across NREQ requesters
module mul8_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_p,
  output logic [15:0]       ops_cnt
);

  logic            s1_v;
  logic [IDW-1:0]  s1_id;
  logic [IDW-1:0]  last;
  logic            hold_v;
  logic [IDW-1:0]  hold_id;
  logic            advance;
  logic            can_accept;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;
  logic [IDW-1:0]  idx;
  logic [NREQ-1:0] grant;
  logic            req_hs;
  logic [7:0]      sel_a;
  logic [7:0]      sel_b;

  assign advance    = !rsp_valid || rsp_ready;
  assign can_accept = !s1_v || advance;
  assign req_ready  = grant & {NREQ{can_accept & rst_n}};
  assign req_hs     = gnt_any && can_accept;

  // Grant: a requester refused last cycle keeps the grant while it stays valid; otherwise round-robin after last
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    grant   = '0;
    if (hold_v && req_valid[hold_id]) begin
      gnt_any = 1'b1;
      gnt_id  = hold_id;
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = IDW'((int'(last) + k) % NREQ);
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    if (gnt_any) grant[gnt_id] = 1'b1;
  end

  // Operand mux for the granted requester
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a = req_a[i*8 +: 8];
        sel_b = req_b[i*8 +: 8];
      end
    end
  end

  // Issue stage: captures the accepted operands, tracks last winner and the grant hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_id   <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      last    <= IDW'(NREQ - 1);
      hold_v  <= 1'b0;
      hold_id <= '0;
    end else begin
      if (can_accept) begin
        s1_v <= req_hs;
        if (req_hs) begin
          mul_a <= sel_a;
          mul_b <= sel_b;
          s1_id <= gnt_id;
          last  <= gnt_id;
        end
      end
      hold_v  <= gnt_any && !can_accept;
      hold_id <= gnt_id;
    end
  end

  // Output stage: captures the shared multiplier product, counts consumed responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      ops_cnt   <= '0;
    end else begin
      if (advance) begin
        rsp_valid <= s1_v;
        if (s1_v) begin
          rsp_p  <= mul_o;
          rsp_id <= s1_id;
        end
      end
      if (rsp_valid && rsp_ready) ops_cnt <= ops_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mul8_share_arb.sv
// tb/tb_mul8_share_arb.sv - self-checking bench for mul8_share_arb
module tb_mul8_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_p;
  logic [15:0] ops_cnt;

  logic [7:0] opa [4];
  logic [7:0] opb [4];

  typedef struct {
    int          id;
    logic [15:0] p;
    int          t;
  } item_t;

  item_t       q[$];
  int          now;
  int          exp_last;
  int          held_v;
  int          held_id;
  logic [15:0] exp_cnt;
  int          n_tests;
  int          n_fail;

  mul8_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .ops_cnt(ops_cnt)
  );

  assign mul_o = 16'(mul_a) * 16'(mul_b);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = opa[i];
      req_b[i*8 +: 8] = opb[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_cnt  = 16'h0000;
    exp_last = 3;
    held_v   = 0;
    held_id  = 0;
  endtask

  // One clock: predict outputs from the transaction-level model, compare, advance the model
  task automatic cyc();
    int          gid;
    int          k_idx;
    logic        ev;
    logic        acc;
    logic [3:0]  er;
    logic [15:0] pr;
    #1;
    gid = -1;
    if (held_v != 0 && req_valid[held_id[1:0]]) gid = held_id;
    else begin
      for (int k = 1; k <= 4; k++) begin
        k_idx = (exp_last + k) % 4;
        if (gid < 0 && req_valid[k_idx[1:0]]) gid = k_idx;
      end
    end
    ev  = (q.size() > 0) && (q[0].t < now);
    acc = (gid >= 0) && (q.size() < 2 || rsp_ready);
    er  = 4'b0000;
    if (acc) er[gid[1:0]] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, ev);
    if (ev) begin
      chk("rsp_id", rsp_id, q[0].id);
      chk("rsp_p", rsp_p, q[0].p);
    end
    chk("ops_cnt", ops_cnt, exp_cnt);
    if (ev && rsp_ready) begin
      void'(q.pop_front());
      exp_cnt = exp_cnt + 16'd1;
    end
    if (acc) begin
      pr = 16'(opa[gid]) * 16'(opb[gid]);
      q.push_back('{id: gid, p: pr, t: now + 1});
      exp_last = gid;
    end
    held_v  = (gid >= 0 && !acc) ? 1 : 0;
    held_id = (gid >= 0) ? gid : 0;
    @(posedge clk);
    now++;
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    now       = 0;
    rst_n     = 1'b0;
    req_valid = 4'h0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      opa[i] = 8'h00;
      opb[i] = 8'h00;
    end
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state, with requests pending
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 4'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 2'd0);
    chk("rst_rsp_p", rsp_p, 16'h0);
    chk("rst_mul_a", mul_a, 8'h0);
    chk("rst_mul_b", mul_b, 8'h0);
    chk("rst_ops_cnt", ops_cnt, 16'h0);
    @(negedge clk);
    req_valid = 4'h0;
    rst_n     = 1'b1;
    @(negedge clk);

    // Single operation from requester 2
    opa[2]    = 8'h0F;
    opb[2]    = 8'h03;
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    #1 chk("single_ready", req_ready, 4'b0100);
    cyc();
    req_valid = 4'h0;
    #1 chk("single_mul_a", mul_a, 8'h0F);
    cyc();
    #1;
    chk("single_rsp_valid", rsp_valid, 1'b1);
    chk("single_rsp_id", rsp_id, 2'd2);
    chk("single_rsp_p", rsp_p, 16'h002D);
    cyc();
    #1 chk("single_ops_cnt", ops_cnt, 16'd1);
    cyc();

    // Round robin with everyone requesting; last winner was 2
    req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      opa[i % 4] = 8'($urandom);
      opb[i % 4] = 8'($urandom);
      #1 chk("rr_order", req_ready, 4'b0001 << ((3 + i) % 4));
      cyc();
    end
    req_valid = 4'h0;
    repeat (3) cyc();

    // Backpressure: two ops in flight, then stall with requester 1 then 0 waiting
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    opa[3] = 8'hC8; opb[3] = 8'h11;
    cyc();
    req_valid = 4'b0100;
    opa[2] = 8'h7E; opb[2] = 8'hFF;
    cyc();
    req_valid = 4'b0010;
    opa[1] = 8'h21; opb[1] = 8'h42;
    opa[0] = 8'h05; opb[0] = 8'h09;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) req_valid = 4'b0011;
      #1;
      chk("bp_req_ready", req_ready, 4'h0);
      chk("bp_rsp_id", rsp_id, 2'd3);
      chk("bp_rsp_p", rsp_p, 16'h0D48);
      cyc();
    end
    rsp_ready = 1'b1;
    #1 chk("hold_grant", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'h0;
    repeat (4) cyc();

    // Counter wrap via backdoor preload
    force dut.ops_cnt = 16'hFFFF;
    #1 release dut.ops_cnt;
    exp_cnt   = 16'hFFFF;
    opa[0]    = 8'($urandom);
    opb[0]    = 8'($urandom);
    req_valid = 4'b0001;
    cyc();
    req_valid = 4'h0;
    cyc();
    cyc();
    #1 chk("cnt_wrap", ops_cnt, 16'h0000);
    cyc();

    // Reset with both stages full
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    cyc();
    cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_ops_cnt", ops_cnt, 16'h0);
    chk("midrst_req_ready", req_ready, 4'h0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    #1 chk("postrst_grant", req_ready, 4'b0001);
    cyc();
    req_valid = 4'h0;
    repeat (3) cyc();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_valid = 4'($urandom);
      for (int j = 0; j < 4; j++) begin
        opa[j] = 8'($urandom);
        opb[j] = 8'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    repeat (4) cyc();
    #1 chk("final_drain", rsp_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
